// File: rtl/derandomizer.sv
// Receive-side inverse of the CCSDS two-LFSR randomizer on a 2-bit valid/ready stream.
// One register stage of latency; the stage may refill in the same cycle it drains.
module derandomizer #(
  parameter int FRAME_SYMS = 1024,
  parameter int CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_data,
  input  logic       i_sof,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [1:0] o_data,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_resync,
  output logic       o_drop
);

  localparam logic [17:0] SEED_X = 18'h00001;
  localparam logic [17:0] SEED_Y = 18'h3FFFF;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SYMS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  function automatic logic [1:0] f_mask(input logic [17:0] x, input logic [17:0] y);
    logic z1, z2;
    z1 = x[4] ^ x[6] ^ x[15];
    z2 = y[5] ^ y[6] ^ (^y[15:8]);
    return {z1 ^ z2, x[0] ^ y[0]};
  endfunction

  function automatic logic [17:0] f_step_x(input logic [17:0] x);
    return {x[7] ^ x[0], x[17:1]};
  endfunction

  function automatic logic [17:0] f_step_y(input logic [17:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [17:0]      r_x;
  logic [17:0]      r_y;

  logic             w_accept;
  logic [17:0]      w_cur_x;
  logic [17:0]      w_cur_y;
  logic [1:0]       w_mask;
  logic             w_last;

  assign o_ready  = ~o_valid | i_ready;
  assign w_accept = i_valid & o_ready;
  // A start-of-codeword symbol always uses the seed, whatever the generator holds.
  assign w_cur_x  = i_sof ? SEED_X : r_x;
  assign w_cur_y  = i_sof ? SEED_Y : r_y;
  assign w_mask   = f_mask(w_cur_x, w_cur_y);
  assign w_last   = (r_cnt == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_x      <= SEED_X;
      r_y      <= SEED_Y;
      o_valid  <= 1'b0;
      o_data   <= 2'b00;
      o_sof    <= 1'b0;
      o_eof    <= 1'b0;
      o_resync <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      o_resync <= 1'b0;
      o_drop   <= 1'b0;
      if (w_accept) begin
        if (i_sof) begin
          o_data   <= i_data ^ w_mask;
          o_sof    <= 1'b1;
          o_eof    <= 1'b0;
          o_valid  <= 1'b1;
          r_x      <= f_step_x(w_cur_x);
          r_y      <= f_step_y(w_cur_y);
          r_cnt    <= CNT_W'(1);
          r_state  <= ST_RUN;
          o_resync <= (r_state == ST_RUN);
        end else if (r_state == ST_IDLE) begin
          o_valid  <= 1'b0;
          o_drop   <= 1'b1;
        end else begin
          o_data   <= i_data ^ w_mask;
          o_sof    <= 1'b0;
          o_eof    <= w_last;
          o_valid  <= 1'b1;
          r_x      <= f_step_x(w_cur_x);
          r_y      <= f_step_y(w_cur_y);
          r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
          r_state  <= w_last ? ST_IDLE : ST_RUN;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_derandomizer.sv
// Directed + randomized bench: keystream model from bit arrays, scoreboard of expected outputs.
module tb_derandomizer;

  localparam int F = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [1:0] i_data = 2'b00;
  logic       i_sof = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_ready, o_sof, o_eof, o_valid, o_resync, o_drop;
  logic [1:0] o_data;

  derandomizer #(.FRAME_SYMS(F), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_sof(i_sof),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_sof(o_sof),
    .o_eof(o_eof), .o_valid(o_valid), .i_ready(i_ready),
    .o_resync(o_resync), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0] d;
    logic       s;
    logic       e;
  } sym_t;

  int         passed = 0;
  int         total = 0;
  int         fails = 0;
  logic [1:0] km [F];
  sym_t       q [$];
  int         fpos = -1;
  logic       held_pend = 1'b0;
  logic [1:0] held_dat = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keystream straight from the generator equations, on per-bit arrays.
  task automatic build_keystream();
    bit xs [18];
    bit ys [18];
    bit nx, ny, z1, z2;
    int taps [10] = '{5, 6, 8, 9, 10, 11, 12, 13, 14, 15};
    for (int i = 0; i < 18; i++) begin
      xs[i] = (i == 0);
      ys[i] = 1'b1;
    end
    for (int k = 0; k < F; k++) begin
      z1 = xs[4] ^ xs[6] ^ xs[15];
      z2 = 1'b0;
      for (int t = 0; t < 10; t++) z2 ^= ys[taps[t]];
      km[k] = {z1 ^ z2, xs[0] ^ ys[0]};
      nx = xs[7] ^ xs[0];
      ny = ys[10] ^ ys[7] ^ ys[5] ^ ys[0];
      for (int i = 0; i < 17; i++) begin
        xs[i] = xs[i+1];
        ys[i] = ys[i+1];
      end
      xs[17] = nx;
      ys[17] = ny;
    end
  endtask

  // One clock: drive at negedge, check outputs, update model, check pulses after the edge.
  task automatic step(input logic v, input logic s, input logic [1:0] d, input logic rdy,
                      output logic acc);
    logic exp_rs, exp_dr, last, have;
    exp_rs = 1'b0;
    exp_dr = 1'b0;
    i_valid = v; i_sof = s; i_data = d; i_ready = rdy;
    #1;
    have = (q.size() != 0);
    chk("o_valid", o_valid, have);
    chk("o_ready", o_ready, !have || rdy);
    if (held_pend) chk("stall_stable", o_data, held_dat);
    held_pend = 1'b0;
    if (have && o_valid) begin
      chk("o_data", o_data, q[0].d);
      chk("o_sof", o_sof, q[0].s);
      chk("o_eof", o_eof, q[0].e);
      if (rdy) void'(q.pop_front());
      else begin
        held_pend = 1'b1;
        held_dat = o_data;
      end
    end
    acc = v && (!have || rdy);
    if (acc) begin
      if (s) begin
        q.push_back('{d ^ km[0], 1'b1, 1'b0});
        exp_rs = (fpos >= 0);
        fpos = 1;
      end else if (fpos < 0) begin
        exp_dr = 1'b1;
      end else begin
        last = (fpos == F - 1);
        q.push_back('{d ^ km[fpos], 1'b0, last});
        fpos = last ? -1 : fpos + 1;
      end
    end
    @(posedge i_clk);
    #1;
    chk("o_resync", o_resync, exp_rs);
    chk("o_drop", o_drop, exp_dr);
    @(negedge i_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_sof"}, o_sof, 0);
    chk({tag, "_eof"}, o_eof, 0);
    chk({tag, "_resync"}, o_resync, 0);
    chk({tag, "_drop"}, o_drop, 0);
  endtask

  initial begin
    logic       acc;
    logic [1:0] p;
    int         n;
    build_keystream();
    chk("km0", km[0], 2'b00);
    chk("km1", km[1], 2'b01);
    chk("km2", km[2], 2'b01);
    chk("km3", km[3], 2'b01);

    // Reset state, then garbage symbols in IDLE.
    #2;
    chk_zero("rst");
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 2'($urandom_range(0, 3)), 1, acc);
    step(0, 0, 0, 1, acc);

    // Seed sequence: sof + 4 zero symbols.
    step(1, 1, 0, 1, acc);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);

    // Round trip (starts with a resync), then a fresh codeword from IDLE.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < F; k++) begin
        p = 2'($urandom_range(0, 3));
        step(1, k == 0, p ^ km[k], 1, acc);
      end
    step(1, 1, 2'b00, 1, acc);
    step(0, 0, 0, 1, acc);
    chk("sof_after_eof_q", q.size(), 0);

    // Backpressure and input gaps across a full codeword.
    n = 1;
    for (int i = 0; i < 300 && n < F; i++) begin
      step($urandom_range(0, 1), 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1), acc);
      if (acc) n++;
    end
    chk("bp_done", n, F);
    step(0, 0, 0, 1, acc);

    // Resync at symbol 5.
    step(1, 1, 2'($urandom_range(0, 3)), 1, acc);
    for (int k = 1; k < 5; k++) step(1, 0, 2'($urandom_range(0, 3)), 1, acc);
    step(1, 1, 0, 1, acc);
    for (int k = 1; k < 4; k++) step(1, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);

    // Reset mid-codeword while the output is stalled.
    step(1, 0, 2'b11, 1, acc);
    step(1, 0, 2'b10, 0, acc);
    i_reset = 1'b1;
    #1;
    chk_zero("midrst");
    q.delete();
    fpos = -1;
    held_pend = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    step(1, 1, 2'b00, 1, acc);
    #1;
    chk("post_rst_mask", o_data, 2'b00);
    @(negedge i_clk);

    // Random soak: random sof placement, valid and ready.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, acc);
    step(0, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
